// File: rtl/conv_seq_pkg.sv
// Shared types and default geometry for the convolution window sequencer.
// Imported by the interface, window register and sequencer FSM.
package conv_seq_pkg;

    localparam int DEF_DEPTH        = 16;
    localparam int DEF_PIX_W        = 9;
    localparam int DEF_SHIFT_N      = 4;
    localparam int DEF_FRAME_PIXELS = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_START,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } conv_seq_state_t;

    typedef enum logic [1:0] {
        WIN_HOLD,
        WIN_CLEAR,
        WIN_LOAD,
        WIN_SHIFT
    } win_op_t;

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Pixel stream, convolver handshake and status bundle of the sequencer.
// master = upstream/convolver side, slave = sequencer.
interface conv_window_sequencer_if
    import conv_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int PIX_W = DEF_PIX_W
);
    logic                        start;
    logic                        pix_valid;
    logic [PIX_W-1:0]            pix_data;
    logic                        pix_ready;
    logic [DEPTH-1:0][PIX_W-1:0] window;
    logic                        buff_full;
    logic                        conv_start;
    logic                        conv_done;
    logic                        busy;
    logic                        frame_done;

    modport master (
        output start, pix_valid, pix_data, conv_done,
        input  pix_ready, window, buff_full,
        input  conv_start, busy, frame_done
    );

    modport slave (
        input  start, pix_valid, pix_data, conv_done,
        output pix_ready, window, buff_full,
        output conv_start, busy, frame_done
    );
endinterface

// File: rtl/window_shift_reg.sv
// Pixel window storage: clear, load-at-index and shift-by-SHIFT_N.
// Entry 0 is the oldest pixel; shifting retires the low entries.
module window_shift_reg
    import conv_seq_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int SHIFT_N = DEF_SHIFT_N,
    parameter int IDX_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  win_op_t                     op,
    input  logic [IDX_W-1:0]            idx,
    input  logic [PIX_W-1:0]            din,
    output logic [DEPTH-1:0][PIX_W-1:0] window
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            window <= '0;
        end else begin
            unique case (op)
                WIN_CLEAR: window <= '0;
                WIN_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (idx == IDX_W'(i)) window[i] <= din;
                    end
                end
                // Packed entry 0 sits in the LSBs, so a right shift retires it.
                WIN_SHIFT: window <= window >> (SHIFT_N * PIX_W);
                default: window <= window;
            endcase
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Fills, pads and shifts the pixel window and hands it to the convolver.
// Control outputs are registered alongside the state.
module conv_window_sequencer
    import conv_seq_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int PIX_W        = DEF_PIX_W,
    parameter int SHIFT_N      = DEF_SHIFT_N,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
    input  logic clk,
    input  logic n_rst,
    conv_window_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

    conv_seq_state_t state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] pix_cnt;
    logic             ready_q;
    logic             conv_start_q;
    logic             frame_done_q;
    logic             busy_q;

    logic             accept;
    logic             idx_last;
    logic             cnt_last;
    logic             cnt_full;
    win_op_t          win_op;
    logic [PIX_W-1:0] win_din;
    logic [DEPTH-1:0][PIX_W-1:0] win_q;

    assign accept   = (state == S_FILL) && bus.pix_valid && ready_q;
    assign idx_last = (idx == IDX_W'(DEPTH - 1));
    assign cnt_last = (pix_cnt == CNT_W'(FRAME_PIXELS - 1));
    assign cnt_full = (pix_cnt == CNT_W'(FRAME_PIXELS));

    always_comb begin
        win_op  = WIN_HOLD;
        win_din = bus.pix_data;
        unique case (1'b1)
            (state == S_IDLE) && bus.start: win_op = WIN_CLEAR;
            accept:                          win_op = WIN_LOAD;
            state == S_PAD: begin
                win_op  = WIN_LOAD;
                win_din = '0;
            end
            state == S_SHIFT:                win_op = WIN_SHIFT;
            default:                         win_op = WIN_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            pix_cnt      <= '0;
            ready_q      <= 1'b0;
            conv_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            conv_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_FILL;
                        idx     <= '0;
                        pix_cnt <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        idx     <= idx + IDX_W'(1);
                        pix_cnt <= pix_cnt + CNT_W'(1);
                        if (idx_last) begin
                            state        <= S_START;
                            ready_q      <= 1'b0;
                            conv_start_q <= 1'b1;
                        end else if (cnt_last) begin
                            state   <= S_PAD;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    idx <= idx + IDX_W'(1);
                    if (idx_last) begin
                        state        <= S_START;
                        conv_start_q <= 1'b1;
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (bus.conv_done) begin
                        if (cnt_full) begin
                            state        <= S_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                // Both FILL invariants (room in window, frame not done) hold here.
                S_SHIFT: begin
                    idx     <= IDX_W'(DEPTH - SHIFT_N);
                    state   <= S_FILL;
                    ready_q <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    window_shift_reg #(
        .DEPTH  (DEPTH),
        .PIX_W  (PIX_W),
        .SHIFT_N(SHIFT_N),
        .IDX_W  (IDX_W)
    ) u_win (
        .clk   (clk),
        .n_rst (n_rst),
        .op    (win_op),
        .idx   (idx),
        .din   (win_din),
        .window(win_q)
    );

    assign bus.window     = win_q;
    assign bus.pix_ready  = ready_q;
    assign bus.buff_full  = (idx == IDX_W'(DEPTH));
    assign bus.conv_start = conv_start_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: three frame lengths, expected
// windows queued per frame and popped on each conv_start.
module tb_conv_window_sequencer;
    import conv_seq_pkg::*;

    localparam int DEPTH   = 16;
    localparam int PIX_W   = 9;
    localparam int SHIFT_N = 4;

    typedef logic [DEPTH-1:0][PIX_W-1:0] win_t;

    typedef struct {
        int sel;
        int frame;
        int base;
        bit bp;
        bit spur;
        int exp_convs;
        int exp_pads;
    } run_t;

    logic             tb_clk = 1'b0;
    logic             n_rst  = 1'b0;
    logic [2:0]       start_v = '0;
    logic             pix_valid = 1'b0;
    logic [PIX_W-1:0] pix_data = '0;
    logic             conv_done = 1'b0;
    int               sel = 0;

    int n_cmp = 0;
    int n_bad = 0;

    logic obs_ready, obs_full, obs_cstart, obs_busy, obs_fdone;
    win_t obs_win;

    always #5 tb_clk = ~tb_clk;

    conv_window_sequencer_if #(.DEPTH(DEPTH), .PIX_W(PIX_W)) bus0 ();
    conv_window_sequencer_if #(.DEPTH(DEPTH), .PIX_W(PIX_W)) bus1 ();
    conv_window_sequencer_if #(.DEPTH(DEPTH), .PIX_W(PIX_W)) bus2 ();

    assign bus0.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus2.start = start_v[2];
    assign bus0.pix_valid = pix_valid;
    assign bus1.pix_valid = pix_valid;
    assign bus2.pix_valid = pix_valid;
    assign bus0.pix_data = pix_data;
    assign bus1.pix_data = pix_data;
    assign bus2.pix_data = pix_data;
    assign bus0.conv_done = conv_done;
    assign bus1.conv_done = conv_done;
    assign bus2.conv_done = conv_done;

    conv_window_sequencer #(
        .DEPTH(DEPTH), .PIX_W(PIX_W), .SHIFT_N(SHIFT_N), .FRAME_PIXELS(20)
    ) dut20 (.clk(tb_clk), .n_rst(n_rst), .bus(bus0));

    conv_window_sequencer #(
        .DEPTH(DEPTH), .PIX_W(PIX_W), .SHIFT_N(SHIFT_N), .FRAME_PIXELS(18)
    ) dut18 (.clk(tb_clk), .n_rst(n_rst), .bus(bus1));

    conv_window_sequencer #(
        .DEPTH(DEPTH), .PIX_W(PIX_W), .SHIFT_N(SHIFT_N), .FRAME_PIXELS(1)
    ) dut1 (.clk(tb_clk), .n_rst(n_rst), .bus(bus2));

    always_comb begin
        obs_ready  = bus0.pix_ready;
        obs_full   = bus0.buff_full;
        obs_cstart = bus0.conv_start;
        obs_busy   = bus0.busy;
        obs_fdone  = bus0.frame_done;
        obs_win    = bus0.window;
        if (sel == 1) begin
            obs_ready  = bus1.pix_ready;
            obs_full   = bus1.buff_full;
            obs_cstart = bus1.conv_start;
            obs_busy   = bus1.busy;
            obs_fdone  = bus1.frame_done;
            obs_win    = bus1.window;
        end else if (sel == 2) begin
            obs_ready  = bus2.pix_ready;
            obs_full   = bus2.buff_full;
            obs_cstart = bus2.conv_start;
            obs_busy   = bus2.busy;
            obs_fdone  = bus2.frame_done;
            obs_win    = bus2.window;
        end
    end

    task automatic chk(input string name, input logic [DEPTH*PIX_W-1:0] act,
                       input logic [DEPTH*PIX_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s sel=%0d got=%0h want=%0h", name, sel, act, exp);
        end
    endtask

    function automatic win_t shifted(input win_t w);
        win_t s = '0;
        for (int j = 0; j < DEPTH - SHIFT_N; j++) s[j] = w[j+SHIFT_N];
        return s;
    endfunction

    task automatic run_frame(input run_t r);
        win_t q[$];
        win_t w, last_w;
        int sent = 0, convs = 0, wait_cnt = -1, shift_chk = 0;
        int g = -1, cyc = 0, lim;
        bit fd_exp = 0, fd_next = 0, fd_seen = 0, rdy_q;
        sel = r.sel;
        last_w = '0;
        for (int k = 0; k < r.exp_convs; k++) begin
            for (int j = 0; j < DEPTH; j++) begin
                int p = k * SHIFT_N + j;
                w[j] = (p < r.frame) ? PIX_W'(r.base + p) : '0;
            end
            q.push_back(w);
        end
        @(negedge tb_clk);
        start_v[r.sel] = 1'b1;
        @(negedge tb_clk);
        start_v = '0;
        chk("ready_after_start", obs_ready, 1);
        chk("busy_after_start", obs_busy, 1);
        pix_data  = PIX_W'(r.base);
        pix_valid = r.bp ? 1'($urandom_range(0, 1)) : 1'b1;
        rdy_q = obs_ready;
        while (!fd_seen && cyc < 3000) begin
            @(negedge tb_clk);
            cyc++;
            if (pix_valid && rdy_q) begin
                sent++;
                if (sent == r.frame) g = cyc;
            end
            fd_exp  = fd_next;
            fd_next = 0;
            chk("frame_done", obs_fdone, fd_exp);
            if (obs_fdone) fd_seen = 1;
            if (shift_chk == 2) begin
                chk("shift_full", obs_full, 1);
                chk("shift_ready", obs_ready, 0);
                shift_chk = 1;
            end else if (shift_chk == 1) begin
                chk("shift_window", obs_win, shifted(last_w));
                chk("refill_ready", obs_ready, 1);
                shift_chk = 0;
            end
            conv_done = 1'b0;
            start_v   = '0;
            if (wait_cnt > 0) begin
                chk("wait_ready", obs_ready, 0);
                chk("wait_full", obs_full, 1);
                wait_cnt--;
                if (wait_cnt == 0) begin
                    conv_done = 1'b1;
                    wait_cnt  = -1;
                    if (convs == r.exp_convs) fd_next = 1;
                    else shift_chk = 2;
                end else if (r.spur) begin
                    start_v[r.sel] = 1'b1;
                end
            end
            if (obs_cstart) begin
                convs++;
                lim = 16 + SHIFT_N * (convs - 1);
                chk("sent_at_conv", sent, (r.frame < lim) ? r.frame : lim);
                if (convs == r.exp_convs) chk("pad_cycles", cyc - g, r.exp_pads);
                if (q.size() == 0) begin
                    chk("extra_conv", convs, r.exp_convs);
                end else begin
                    last_w = q.pop_front();
                    chk("conv_window", obs_win, last_w);
                end
                wait_cnt = 1 + $urandom_range(0, 2);
            end
            if (r.spur && wait_cnt < 0 && !conv_done && !fd_seen)
                conv_done = ($urandom_range(0, 3) == 0);
            if (sent >= r.frame) chk("ready_after_last", obs_ready, 0);
            pix_data  = PIX_W'(r.base + sent);
            pix_valid = r.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy_q = obs_ready;
        end
        chk("frame_done_seen", fd_seen, 1);
        chk("conv_count", convs, r.exp_convs);
        chk("handshakes", sent, r.frame);
        chk("busy_in_done", obs_busy, 1);
        pix_valid = 1'b0;
        conv_done = 1'b0;
        start_v   = '0;
        @(negedge tb_clk);
        chk("busy_after_done", obs_busy, 0);
        chk("ready_idle", obs_ready, 0);
    endtask

    run_t runs[5];
    win_t e;

    initial begin
        runs[0] = '{sel: 0, frame: 20, base: 1,   bp: 0, spur: 0, exp_convs: 2, exp_pads: 0};
        runs[1] = '{sel: 1, frame: 18, base: 1,   bp: 0, spur: 0, exp_convs: 2, exp_pads: 2};
        runs[2] = '{sel: 2, frame: 1,  base: 7,   bp: 0, spur: 0, exp_convs: 1, exp_pads: 15};
        runs[3] = '{sel: 0, frame: 20, base: 100, bp: 1, spur: 1, exp_convs: 2, exp_pads: 0};
        runs[4] = '{sel: 1, frame: 18, base: 300, bp: 1, spur: 1, exp_convs: 2, exp_pads: 2};

        repeat (3) @(negedge tb_clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            chk("rst_ready", obs_ready, 0);
            chk("rst_busy", obs_busy, 0);
            chk("rst_full", obs_full, 0);
            chk("rst_cstart", obs_cstart, 0);
            chk("rst_fdone", obs_fdone, 0);
            chk("rst_window", obs_win, '0);
        end
        sel = 0;
        n_rst = 1'b1;

        // Reset in the middle of a fill, with seven pixels loaded.
        @(negedge tb_clk);
        start_v[0] = 1'b1;
        @(negedge tb_clk);
        start_v = '0;
        for (int i = 0; i < 7; i++) begin
            pix_valid = 1'b1;
            pix_data  = PIX_W'(11 + i);
            @(negedge tb_clk);
        end
        e = '0;
        for (int i = 0; i < 7; i++) e[i] = PIX_W'(11 + i);
        chk("fill7_window", obs_win, e);
        chk("fill7_full", obs_full, 0);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_window", obs_win, '0);
        chk("mid_rst_ready", obs_ready, 0);
        chk("mid_rst_busy", obs_busy, 0);
        chk("mid_rst_full", obs_full, 0);
        @(negedge tb_clk);
        n_rst = 1'b1;
        @(negedge tb_clk);
        chk("post_rst_ready", obs_ready, 0);
        chk("post_rst_busy", obs_busy, 0);
        pix_valid = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(runs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog sel=%0d got=timeout want=finish", sel);
        $fatal(1);
    end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Controller that sequences the edge-detection pixel window buffer between the AHB master's pixel stream and the convolution engine. It accepts pixels over a valid/ready handshake, packs them into a DEPTH-entry window, fires the convolver when the window is full, and waits for completion. It then shifts the oldest SHIFT_N pixels out and refills. At frame end it zero-pads a partial window and reports frame completion.

## Interface
- DEPTH, 16, window entries (≥2)
- PIX_W, 9, pixel width in bits
- SHIFT_N, 4, entries retired per convolution (1..DEPTH)
- FRAME_PIXELS, 1024, pixels per frame (≥1)

- clk  in  1  system clock, rising edge
- n_rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  begin frame; honoured only in IDLE
- pix_valid  in  1  pixel present on pix_data
- pix_data  in  PIX_W  incoming pixel (already scaled by upstream /16)
- pix_ready  out  1  controller accepts pixel this cycle
- window  out  DEPTH×PIX_W  registered window, entry 0 = oldest
- buff_full  out  1  window holds DEPTH valid/padded entries
- conv_start  out  1  one-cycle pulse to convolver
- conv_done  in  1  convolver finished; sampled only in WAIT
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse after last convolution

## Operation
- States: IDLE, FILL, PAD, START, WAIT, SHIFT, DONE.
- Counters: idx (0..DEPTH, $clog2(DEPTH+1) bits), pix_cnt (0..FRAME_PIXELS, $clog2(FRAME_PIXELS+1) bits); no wrap, both saturate by construction.
- IDLE: pix_ready=0. start → FILL; idx, pix_cnt, window cleared.
- FILL: pix_ready = (idx<DEPTH) && (pix_cnt<FRAME_PIXELS). On pix_valid&&pix_ready: window[idx]←pix_data, idx++, pix_cnt++. If the accepted pixel makes idx==DEPTH → START. Else if it makes pix_cnt==FRAME_PIXELS → PAD.
- PAD: window[idx]←0, idx++ per cycle. On reaching DEPTH → START. pix_ready=0.
- START: conv_start=1 for exactly one cycle → WAIT.
- WAIT: on conv_done, if pix_cnt==FRAME_PIXELS → DONE, else → SHIFT. conv_done outside WAIT is ignored.
- SHIFT: window[i]←window[i+SHIFT_N] for i<DEPTH−SHIFT_N; tail entries ←0; idx←DEPTH−SHIFT_N → FILL.
- DONE: frame_done=1 one cycle → IDLE. Window retains final contents.
- buff_full = (idx==DEPTH); true in START, WAIT, and the SHIFT cycle.
- start while busy: ignored. pix_valid outside FILL: not accepted; the upstream holds the pixel.

## Timing
- Reset: state IDLE; idx=0, pix_cnt=0, window all 0; pix_ready, buff_full, conv_start, busy, frame_done all 0.
- start at edge N → FILL at N+1; pix_ready high in that cycle.
- One pixel per cycle max in FILL. conv_start asserts the cycle after the DEPTHth accept.
- Earliest turnaround: conv_done at edge M → SHIFT at M+1 → FILL at M+2.
- Pad latency: one cycle per padded entry.
- Reset mid-operation: immediate return to reset values. No pulse is emitted. A pending convolution is abandoned.

## Structure
- Package conv_seq_pkg: state enum conv_seq_state_t, default DEPTH/PIX_W/SHIFT_N constants.
- Sub-module window_shift_reg: holds window and performs load-at-index, zero-pad, and shift-by-SHIFT_N. The FSM and counters remain in conv_window_sequencer.

## Test plan
- Reset: assert n_rst=0 mid-FILL with idx=7 → all outputs 0, state IDLE next cycle, later start accepted normally.
- Full frame, FRAME_PIXELS=20, pixels 1..20 always valid:
  - First conv_start after pixel 16 with window=1..16.
  - After conv_done the window is 5..16,0,0,0,0, then 5..20.
  - Second conv_start, conv_done → frame_done one cycle later, busy drops.
- Padding, FRAME_PIXELS=18:
  - After shift, pixels 17,18 accepted, then 2 pad cycles.
  - Window=5..18,0,0, then conv_start, conv_done → frame_done.
- Backpressure: pix_valid toggled 1/0 randomly → exactly FRAME_PIXELS handshakes. pix_ready=0 in START/WAIT/SHIFT/PAD; no pixel dropped or duplicated.
- Spurious inputs: conv_done pulsed in FILL and start pulsed in WAIT → no state change. conv_start count equals the expected ceil-based window count (2 for 20 pixels).
- Short frame, FRAME_PIXELS=1: pixel 7 → 15 pad cycles, window=7,0…0, conv_start, conv_done → frame_done.
